// File: rtl/seg7_scan_display_pkg.sv
// Shared types and constants for the multiplexed 7-segment score display.
// Glyphs are {a,b,c,d,e,f,g,dp}, active-low.
package seg7_scan_display_pkg;

    localparam int unsigned DEF_REFRESH_DIV = 50000;

    typedef enum logic [1:0] {
        CONV_IDLE   = 2'd0,
        CONV_SHIFT  = 2'd1,
        CONV_COMMIT = 2'd2
    } conv_state_t;

    localparam logic [7:0] GLYPH_DASH  = 8'b11111101;
    localparam logic [7:0] GLYPH_BLANK = 8'hFF;

    // Decimal digit to segment pattern; non-decimal nibbles never reach here
    function automatic logic [7:0] glyph(input logic [3:0] digit);
        case (digit)
            4'd0:    glyph = 8'b00000011;
            4'd1:    glyph = 8'b10011111;
            4'd2:    glyph = 8'b00100101;
            4'd3:    glyph = 8'b00001101;
            4'd4:    glyph = 8'b10011001;
            4'd5:    glyph = 8'b01001001;
            4'd6:    glyph = 8'b01000001;
            4'd7:    glyph = 8'b00011111;
            4'd8:    glyph = 8'b00000001;
            4'd9:    glyph = 8'b00001001;
            default: glyph = GLYPH_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// Request/status bundle between the score logic and the display driver.
interface seg7_scan_display_if #(
    parameter int unsigned BIN_W = 16
);
    logic [BIN_W-1:0] value_in;
    logic             load;
    logic             busy;
    logic             done;
    logic             overflow;

    modport master (output value_in, load, input busy, done, overflow);
    modport slave  (input value_in, load, output busy, done, overflow);
endinterface

// File: rtl/seg7_scan_display_bcd_serial_conv.sv
// Serial double-dabble converter: one input bit per cycle, result committed
// atomically; loads arriving mid-conversion are coalesced into one pending value.
module seg7_scan_display_bcd_serial_conv
    import seg7_scan_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned BIN_W      = 16
) (
    input  logic                    clk_mid,
    input  logic                    rst,
    input  logic [BIN_W-1:0]        bin,
    input  logic                    load,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    ovf,
    output logic                    busy,
    output logic                    done
);
    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    conv_state_t      state;
    logic [BIN_W-1:0] shreg;
    logic [BIN_W-1:0] pend_val;
    logic             pend;
    logic [BCD_W-1:0] acc;
    logic [BCD_W-1:0] adj_c;
    logic [CNT_W-1:0] bit_cnt;
    logic             ovf_acc;

    // Add-3 correction on every nibble that would overflow past 9 after doubling
    always_comb begin
        adj_c = acc;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (acc[4*k +: 4] >= 4'd5) adj_c[4*k +: 4] = acc[4*k +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk_mid or posedge rst) begin
        if (rst) begin
            state    <= CONV_IDLE;
            shreg    <= '0;
            pend_val <= '0;
            pend     <= 1'b0;
            acc      <= '0;
            bit_cnt  <= '0;
            ovf_acc  <= 1'b0;
            bcd      <= '0;
            ovf      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                CONV_IDLE: begin
                    if (load) begin
                        shreg   <= bin;
                        acc     <= '0;
                        bit_cnt <= '0;
                        ovf_acc <= 1'b0;
                        busy    <= 1'b1;
                        state   <= CONV_SHIFT;
                    end
                end
                CONV_SHIFT: begin
                    acc     <= {adj_c[BCD_W-2:0], shreg[BIN_W-1]};
                    shreg   <= shreg << 1;
                    ovf_acc <= ovf_acc | adj_c[BCD_W-1];
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(BIN_W - 1)) state <= CONV_COMMIT;
                    if (load) begin
                        pend     <= 1'b1;
                        pend_val <= bin;
                    end
                end
                CONV_COMMIT: begin
                    bcd  <= acc;
                    ovf  <= ovf_acc;
                    done <= 1'b1;
                    // A load seen this cycle is newer than anything held pending
                    if (load || pend) begin
                        shreg   <= load ? bin : pend_val;
                        pend    <= 1'b0;
                        acc     <= '0;
                        bit_cnt <= '0;
                        ovf_acc <= 1'b0;
                        state   <= CONV_SHIFT;
                    end else begin
                        busy  <= 1'b0;
                        state <= CONV_IDLE;
                    end
                end
                default: state <= CONV_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed 7-segment score display: serial BCD conversion into a tear-free
// display register, anode scan with leading-zero blanking and overflow dashes.
module seg7_scan_display
    import seg7_scan_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned BIN_W       = 16,
    parameter int unsigned REFRESH_DIV = DEF_REFRESH_DIV,
    parameter int unsigned BLANK_LZ    = 1
) (
    input  logic                  clk_mid,
    input  logic                  rst,
    seg7_scan_display_if.slave    bus,
    output logic [NUM_DIGITS-1:0] an,
    output logic [7:0]            seg
);
    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [BCD_W-1:0]      disp;
    logic [PRE_W-1:0]      presc;
    logic [IDX_W-1:0]      idx;
    logic                  tc_c;
    logic                  zero_above;
    logic [NUM_DIGITS-1:0] lz_c;
    logic [3:0]            nib_c;
    logic                  blank_c;
    logic [NUM_DIGITS-1:0] an_c;
    logic [7:0]            seg_c;

    seg7_scan_display_bcd_serial_conv #(
        .NUM_DIGITS (NUM_DIGITS),
        .BIN_W      (BIN_W)
    ) u_bcd_serial_conv (
        .clk_mid (clk_mid),
        .rst     (rst),
        .bin     (bus.value_in),
        .load    (bus.load),
        .bcd     (disp),
        .ovf     (bus.overflow),
        .busy    (bus.busy),
        .done    (bus.done)
    );

    assign tc_c = (presc == PRE_W'(REFRESH_DIV - 1));

    // Digit select, leading-zero detect and glyph/dash/blank choice
    always_comb begin
        zero_above = 1'b1;
        lz_c       = '0;
        nib_c      = '0;
        blank_c    = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above & (disp[4*k +: 4] == 4'd0);
            lz_c[k]    = zero_above;
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                nib_c   = disp[4*k +: 4];
                blank_c = (k != 0) && lz_c[k];
            end
        end
        an_c = ~(NUM_DIGITS'(1) << idx);
        if (bus.overflow)                     seg_c = GLYPH_DASH;
        else if ((BLANK_LZ != 0) && blank_c)  seg_c = GLYPH_BLANK;
        else                                  seg_c = glyph(nib_c);
    end

    // an/seg reload together at each refresh tick, so a digit never tears
    always_ff @(posedge clk_mid or posedge rst) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
            an    <= '1;
            seg   <= GLYPH_BLANK;
        end else if (tc_c) begin
            presc <= '0;
            an    <= an_c;
            seg   <= seg_c;
            idx   <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end else begin
            presc <= presc + PRE_W'(1);
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: expected conversions are queued at load
// time and retired on done; an independent scan model checks an/seg every cycle.
module tb_seg7_scan_display;

    localparam int unsigned ND    = 4;
    localparam int unsigned BW    = 16;
    localparam int unsigned RD    = 4;
    localparam int unsigned LIMIT = 10000;

    typedef struct {
        int unsigned val;
        bit          ovf;
    } exp_t;

    logic          clk_mid = 1'b0;
    logic          rst;
    logic [ND-1:0] an, an_nb;
    logic [7:0]    seg, seg_nb;

    seg7_scan_display_if #(.BIN_W(BW)) bus ();
    seg7_scan_display_if #(.BIN_W(BW)) bus_nb ();

    assign bus_nb.value_in = bus.value_in;
    assign bus_nb.load     = bus.load;

    seg7_scan_display #(.NUM_DIGITS(ND), .BIN_W(BW), .REFRESH_DIV(RD), .BLANK_LZ(1)) dut (
        .clk_mid (clk_mid),
        .rst     (rst),
        .bus     (bus),
        .an      (an),
        .seg     (seg)
    );

    seg7_scan_display #(.NUM_DIGITS(ND), .BIN_W(BW), .REFRESH_DIV(RD), .BLANK_LZ(0)) dut_nb (
        .clk_mid (clk_mid),
        .rst     (rst),
        .bus     (bus_nb),
        .an      (an_nb),
        .seg     (seg_nb)
    );

    always #5 clk_mid = ~clk_mid;

    int   n_total = 0;
    int   n_bad   = 0;
    int   n_done  = 0;
    exp_t sb[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] glyph_ref(input int unsigned d);
        case (d)
            0: return 8'b00000011;
            1: return 8'b10011111;
            2: return 8'b00100101;
            3: return 8'b00001101;
            4: return 8'b10011001;
            5: return 8'b01001001;
            6: return 8'b01000001;
            7: return 8'b00011111;
            8: return 8'b00000001;
            9: return 8'b00001001;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] seg_ref(input int unsigned val, input bit ovf,
                                           input int unsigned k, input bit blank);
        int unsigned p = 1;
        for (int i = 0; i < int'(k); i++) p = p * 10;
        if (ovf) return 8'b11111101;
        if (blank && k > 0 && val < p) return 8'hFF;
        return glyph_ref((val / p) % 10);
    endfunction

    // Scan model: counts clock edges since reset release
    bit            rst_at_edge = 1'b0;
    int unsigned   edges = 0;
    int unsigned   mdl_val = 0;
    bit            mdl_ovf = 1'b0;
    logic [ND-1:0] e_an = '1;
    logic [7:0]    e_seg = 8'hFF;
    logic [7:0]    e_seg_nb = 8'hFF;

    always @(posedge clk_mid) rst_at_edge <= rst;

    always @(negedge clk_mid) begin : monitor
        int unsigned k;
        exp_t        e;
        if (rst) begin
            edges    = 0;
            mdl_val  = 0;
            mdl_ovf  = 1'b0;
            e_an     = '1;
            e_seg    = 8'hFF;
            e_seg_nb = 8'hFF;
        end else if (!rst_at_edge) begin
            edges++;
            if (edges % RD == 0) begin
                k        = (edges / RD - 1) % ND;
                e_an     = ~(ND'(1) << k);
                e_seg    = seg_ref(mdl_val, mdl_ovf, k, 1'b1);
                e_seg_nb = seg_ref(mdl_val, mdl_ovf, k, 1'b0);
            end
        end
        check_eq("an", 32'(an), 32'(e_an));
        check_eq("seg", 32'(seg), 32'(e_seg));
        check_eq("an_nb", 32'(an_nb), 32'(e_an));
        check_eq("seg_nb", 32'(seg_nb), 32'(e_seg_nb));
        if (bus.done) begin
            n_done++;
            check_eq("done_has_entry", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_eq("overflow", 32'(bus.overflow), 32'(e.ovf));
                check_eq("overflow_nb", 32'(bus_nb.overflow), 32'(e.ovf));
                mdl_val = e.val;
                mdl_ovf = e.ovf;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk_mid);
        #1;
    endtask

    // Called just after a posedge; load is sampled on the next posedge
    task automatic do_load(input int unsigned v, input bit replace);
        exp_t e;
        e.val = v;
        e.ovf = (v >= LIMIT);
        bus.value_in = BW'(v);
        bus.load     = 1'b1;
        if (replace && sb.size() > 0) sb[sb.size()-1] = e;
        else                          sb.push_back(e);
        @(posedge clk_mid);
        #1;
        bus.load = 1'b0;
    endtask

    task automatic timed_load(input int unsigned v);
        int done_k   = -1;
        int busy_cnt = 0;
        do_load(v, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (bus.done) begin
                done_k = i;
                check_eq("busy_at_done", 32'(bus.busy), 32'd0);
                break;
            end
            if (bus.busy) busy_cnt++;
            @(posedge clk_mid);
            #1;
        end
        check_eq("done_edge", 32'(done_k), 32'd17);
        check_eq("busy_cycles", 32'(busy_cnt), 32'd17);
    endtask

    initial begin
        int d0;
        int drops;
        int dcount;
        rst          = 1'b1;
        bus.load     = 1'b0;
        bus.value_in = '0;
        idle(3);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_ovf", 32'(bus.overflow), 32'd0);
        check_eq("rst_an", 32'(an), 32'hF);
        check_eq("rst_seg", 32'(seg), 32'hFF);
        rst = 1'b0;

        // Idle scan: dark for RD cycles, then digit 0 shows "0"
        idle(3);
        check_eq("an_pre_light", 32'(an), 32'hF);
        idle(1);
        check_eq("an_first", 32'(an), 32'b1110);
        check_eq("seg_first", 32'(seg), 32'b00000011);
        idle(20);

        timed_load(1234);
        idle(40);
        timed_load(7);
        idle(40);
        timed_load(12345);
        idle(40);
        check_eq("ovf_hold", 32'(bus.overflow), 32'd1);
        timed_load(9999);
        idle(40);
        check_eq("ovf_clear", 32'(bus.overflow), 32'd0);

        // Back-to-back loads: 2222 is superseded by 3333 while pending
        d0     = n_done;
        drops  = 0;
        dcount = 0;
        do_load(1111, 1'b0);
        for (int i = 0; i < 2; i++) begin
            if (!bus.busy) drops++;
            @(posedge clk_mid);
            #1;
        end
        do_load(2222, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (!bus.busy) drops++;
            @(posedge clk_mid);
            #1;
        end
        do_load(3333, 1'b1);
        for (int i = 0; i < 80; i++) begin
            if (bus.done) dcount++;
            if (dcount == 2) break;
            if (!bus.busy) drops++;
            @(posedge clk_mid);
            #1;
        end
        check_eq("t5_dones", 32'(dcount), 32'd2);
        check_eq("t5_busy_drops", 32'(drops), 32'd0);
        idle(40);
        check_eq("t5_done_total", 32'(n_done - d0), 32'd2);

        // Reset mid-conversion discards both the conversion and its result
        d0 = n_done;
        do_load(4321, 1'b0);
        idle(8);
        rst = 1'b1;
        sb.delete();
        #1;
        check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
        check_eq("mid_rst_done", 32'(bus.done), 32'd0);
        check_eq("mid_rst_ovf", 32'(bus.overflow), 32'd0);
        check_eq("mid_rst_an", 32'(an), 32'hF);
        check_eq("mid_rst_seg", 32'(seg), 32'hFF);
        @(posedge clk_mid);
        #1;
        rst = 1'b0;
        idle(40);
        check_eq("t6_no_done", 32'(n_done - d0), 32'd0);
        check_eq("t6_busy", 32'(bus.busy), 32'd0);
        check_eq("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
